// File: rtl/instr_loader_pkg.sv
// Shared CPU package: instruction-entry state encoding, field widths and the
// default debounce length used by both the loader and the core control FSM.
package instr_loader_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

  localparam int NIB_W    = 4;
  localparam int INSTR_W  = 12;
  localparam int SHADOW_W = 16;

  // Encoding doubles as the nibble index shown on the status LEDs.
  typedef enum logic [1:0] {
    S_OP = 2'd0,
    S_N2 = 2'd1,
    S_N1 = 2'd2,
    S_N0 = 2'd3
  } entry_state_t;

  function automatic entry_state_t next_entry_state(input entry_state_t state);
    case (state)
      S_OP:    return S_N2;
      S_N2:    return S_N1;
      S_N1:    return S_N0;
      default: return S_OP;
    endcase
  endfunction

endpackage

// File: rtl/instr_loader_btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stability counter and a
// registered one-cycle pulse on each debounced press.
module btn_debounce
  import instr_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn,
  output logic btn_edge
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic             btn_sync;
  logic             level;
  logic [CNT_W-1:0] cnt;

  assign btn_sync = sync[1];

  // NOTE: every flop here uses non-blocking assignment so all state updates
  // see pre-edge values; blocking would silently collapse the synchronizer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync     <= '0;
      level    <= 1'b0;
      cnt      <= '0;
      btn_edge <= 1'b0;
    end else begin
      sync     <= {sync[0], btn};
      btn_edge <= 1'b0;
      if (btn_sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Decision edge: pulse only when the level flips to pressed.
        level    <= btn_sync;
        cnt      <= '0;
        btn_edge <= btn_sync;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Front-panel instruction loader: four debounced presses enter opcode plus
// three operand nibbles, published to the core as one complete instruction.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 5
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NIB_W-1:0]   sw,
  input  logic               btn,
  input  logic               clr,
  output logic [NIB_W-1:0]   opcode,
  output logic [INSTR_W-1:0] instr,
  output logic               inst_done,
  output logic               btn_edge,
  output logic [1:0]         nib_idx
);

  logic [NIB_W-1:0]    sw_meta;
  logic [NIB_W-1:0]    sw_sync;
  entry_state_t        state;
  logic [SHADOW_W-1:0] shadow;
  logic [SHADOW_W-1:0] shadow_next;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btn_debounce (
    .clk     (clk),
    .rstn    (rstn),
    .btn     (btn),
    .btn_edge(btn_edge)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  // NOTE: shadow_next is assigned a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    shadow_next = shadow;
    case (state)
      S_OP:    shadow_next[15:12] = sw_sync;
      S_N2:    shadow_next[11:8]  = sw_sync;
      S_N1:    shadow_next[7:4]   = sw_sync;
      default: shadow_next[3:0]   = sw_sync;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_OP;
      shadow    <= '0;
      opcode    <= '0;
      instr     <= '0;
      inst_done <= 1'b0;
    end else begin
      inst_done <= 1'b0;
      if (clr) begin
        // Abort wins over a coincident press; published outputs stay intact.
        state  <= S_OP;
        shadow <= '0;
      end else if (btn_edge) begin
        shadow <= shadow_next;
        state  <= next_entry_state(state);
        if (state == S_N0) begin
          opcode    <= shadow_next[15:12];
          instr     <= shadow_next[11:0];
          inst_done <= 1'b1;
        end
      end
    end
  end

  assign nib_idx = state;

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: number of consecutive stable cycles required before the debounced button level changes.
REQ-002 Parameter CNT_W, default 5: width of the debounce counter; SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rstn  input  1  synchronous, active-low reset.
REQ-005 sw  input  4  raw nibble switches; asynchronous to clk.
REQ-006 btn  input  1  raw push-button; asynchronous and bouncing; high = pressed.
REQ-007 clr  input  1  synchronous abort of a partially entered instruction; active-high.
REQ-008 opcode  output  4  opcode of the last completed instruction, consumed by the CPU core.
REQ-009 instr  output  12  operand field of the last completed instruction.
REQ-010 inst_done  output  1  one-cycle pulse; opcode and instr are new and valid in this cycle.
REQ-011 btn_edge  output  1  one-cycle pulse on each debounced press; also forwarded to the core.
REQ-012 nib_idx  output  2  index of the next nibble to be entered (0 = opcode), for status LEDs.

Function
REQ-013 sw and btn SHALL each pass through a 2-flop synchronizer before any other use.
REQ-014 Debounce: the counter clears whenever the synchronized btn equals the debounced level; otherwise it increments; after DEBOUNCE_CYCLES consecutive mismatching cycles the debounced level takes the new value and the counter clears.
REQ-015 btn_edge SHALL be registered and high for exactly the one cycle following the edge at which the debounced level goes 0->1; a held button SHALL produce exactly one pulse; release produces none.
REQ-016 Entry FSM states: S_OP, S_N2, S_N1, S_N0, encoded 0..3; nib_idx SHALL equal the state encoding.
REQ-017 At each clock edge where btn_edge=1 and clr=0, the synchronized sw SHALL be captured into a 16-bit shadow register: S_OP -> shadow[15:12], S_N2 -> [11:8], S_N1 -> [7:4], S_N0 -> [3:0]; the state then advances S_OP->S_N2->S_N1->S_N0->S_OP.
REQ-018 On the S_N0 capture edge, opcode SHALL load {shadow[15:12]}, instr SHALL load {shadow[11:4], sw_sync}, and inst_done SHALL be 1 in the immediately following cycle only.
REQ-019 opcode and instr SHALL change only on completion (REQ-018) or reset; partial entry SHALL never disturb them.
REQ-020 clr=1 SHALL return the FSM to S_OP and zero the shadow register; opcode, instr and the debouncer are unaffected.
REQ-021 clr and btn_edge in the same cycle: clr wins; no capture occurs and inst_done stays 0.
REQ-022 Latency: a debounced press is visible on btn_edge 1 cycle after the debounce decision; inst_done follows the fourth btn_edge by 1 cycle.

Reset
REQ-023 While rstn=0 at a clock edge: opcode=0, instr=0, inst_done=0, btn_edge=0, nib_idx=0 (S_OP), shadow=0, debounced level=0, debounce counter=0, synchronizer flops=0.
REQ-024 Reset mid-entry SHALL discard the partial instruction; a button still held when rstn rises SHALL produce a btn_edge after DEBOUNCE_CYCLES stable cycles.

Structure
REQ-025 The FSM state encoding and the DEBOUNCE_CYCLES default SHALL live in the shared CPU package used by the core's control FSM.
REQ-026 Synchronizer, debounce counter and edge detector SHALL form one sub-module, btn_debounce, instantiated once.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-027 Clean presses with sw=9,1,2,3 -> four btn_edge pulses, nib_idx 0->1->2->3->0, opcode=4'h9, instr=12'h123, inst_done exactly one cycle.
REQ-028 btn toggling with high periods of 1-3 cycles for 50 cycles -> no btn_edge, nib_idx unchanged.
REQ-029 btn held 200 cycles -> exactly one btn_edge.
REQ-030 Enter 9,1 then clr, then enter A,B,C,D -> opcode=4'hA, instr=12'hBCD; opcode/instr keep prior values until that inst_done.
REQ-031 rstn low after two nibbles -> all outputs 0, nib_idx=0; next four presses assemble a fresh instruction.
REQ-032 Two back-to-back instructions 9123 then 5ABC -> outputs stay 9/123 throughout the second entry, switch to 5/ABC with the second inst_done.
